// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer configuration sequencer.
// Holds the FSM encoding and the round-robin distance helper.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        LOAD     = 2'd2,
        DONE     = 2'd3
    } seq_state_e;

    localparam int TIMER_W = 8;
    localparam logic [TIMER_W-1:0] PERIOD_RESET = 8'd255;

    // Number of steps from the pointer forward to idx, wrapping at n.
    function automatic int rr_distance(input int ptr, input int idx, input int n);
        return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
    endfunction

endpackage

// File: rtl/timer_config_sequencer_rr_arbiter.sv
// Pointer-based round-robin arbiter: grants the first request at or after
// the pointer and moves the pointer past the winner on each advance strobe.
module rr_arbiter
    import timer_ctrl_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] grant_o
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    int               best_dist;

    // Closest asserted request (in wrap order from the pointer) wins.
    always_comb begin
        grant_o   = '0;
        ptr_d     = ptr_q;
        best_dist = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_i[i] && (rr_distance(int'(ptr_q), i, N_REQ) < best_dist)) begin
                best_dist  = rr_distance(int'(ptr_q), i, N_REQ);
                grant_o    = '0;
                grant_o[i] = 1'b1;
                ptr_d      = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/timer_config_sequencer.sv
// Shares the timer's enable/period/prescaler inputs between requesters:
// arbitrates, optionally waits for a period boundary, then reloads the timer.
module timer_config_sequencer
    import timer_ctrl_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [TIMER_W*N_REQ-1:0] cfg_period_i,
    input  logic [TIMER_W*N_REQ-1:0] cfg_prescaler_i,
    input  logic [N_REQ-1:0]         cfg_sync_i,
    input  logic                     period_complete_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic                     timer_enable_o,
    output logic [TIMER_W-1:0]       period_o,
    output logic [TIMER_W-1:0]       prescaler_o,
    output logic                     busy_o,
    output logic                     sync_timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int LD_W  = $clog2(LOAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [LD_W-1:0]  LD_LAST = LD_W'(LOAD_CYCLES - 1);

    seq_state_e         state_q, state_d;
    logic [N_REQ-1:0]   arb_grant;
    logic               arb_advance;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [TIMER_W-1:0] sel_period, sel_prescaler;
    logic               sel_sync;
    logic [TIMER_W-1:0] lat_period_q, lat_period_d;
    logic [TIMER_W-1:0] lat_presc_q, lat_presc_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [LD_W-1:0]    load_cnt_q, load_cnt_d;
    logic               en_q, en_d;
    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] presc_q, presc_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic               any_req;
    logic               timed_out;

    assign any_req     = |req_i;
    assign timed_out   = (wait_cnt_q == CNT_MAX);
    assign arb_advance = (state_q == IDLE) && any_req;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req_i),
        .advance_i (arb_advance),
        .grant_o   (arb_grant)
    );

    always_comb begin
        sel_period    = '0;
        sel_prescaler = '0;
        sel_sync      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_period    = sel_period | cfg_period_i[i*TIMER_W +: TIMER_W];
                sel_prescaler = sel_prescaler | cfg_prescaler_i[i*TIMER_W +: TIMER_W];
                sel_sync      = sel_sync | cfg_sync_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            lat_period_q <= PERIOD_RESET;
            lat_presc_q  <= '0;
            wait_cnt_q   <= '0;
            load_cnt_q   <= '0;
            en_q         <= 1'b0;
            period_q     <= PERIOD_RESET;
            presc_q      <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            lat_period_q <= lat_period_d;
            lat_presc_q  <= lat_presc_d;
            wait_cnt_q   <= wait_cnt_d;
            load_cnt_q   <= load_cnt_d;
            en_q         <= en_d;
            period_q     <= period_d;
            presc_q      <= presc_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    // A boundary pulse beats a run drop, which beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (any_req) state_d = (sel_sync && en_q) ? WAIT_BND : LOAD;
            WAIT_BND: if (period_complete_i || !run_i || timed_out) state_d = LOAD;
            LOAD:     if (load_cnt_q == LD_LAST) state_d = DONE;
            DONE:     if ((req_i & grant_q) == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d      = grant_q;
        lat_period_d = lat_period_q;
        lat_presc_d  = lat_presc_q;
        wait_cnt_d   = wait_cnt_q;
        load_cnt_d   = load_cnt_q;
        en_d         = en_q;
        period_d     = period_q;
        presc_d      = presc_q;
        ack_d        = ack_q;
        timeout_d    = timeout_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                en_d = run_i;
                if (any_req) begin
                    grant_d      = arb_grant;
                    lat_period_d = sel_period;
                    lat_presc_d  = sel_prescaler;
                    timeout_d    = 1'b0;
                end
            end
            WAIT_BND: begin
                if (!timed_out) wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (timed_out && run_i && !period_complete_i) timeout_d = 1'b1;
            end
            LOAD:    load_cnt_d = load_cnt_q + LD_W'(1);
            DONE:    en_d = run_i;
            default: ;
        endcase
        if (state_d == WAIT_BND && state_q != WAIT_BND) begin
            wait_cnt_d = '0;
            en_d       = 1'b1;
        end
        // The timer captures the new period while its enable is low.
        if (state_d == LOAD && state_q != LOAD) begin
            load_cnt_d = '0;
            en_d       = 1'b0;
            period_d   = lat_period_d;
            presc_d    = lat_presc_d;
        end
        if (state_d == DONE && state_q != DONE) begin
            ack_d = grant_q;
            en_d  = run_i;
        end
        if (state_d == IDLE && state_q == DONE) ack_d = '0;
    end

    assign ack_o          = ack_q;
    assign timer_enable_o = en_q;
    assign period_o       = period_q;
    assign prescaler_o    = presc_q;
    assign busy_o         = busy_q;
    assign sync_timeout_o = timeout_q;

endmodule

// File: tb/tb_timer_config_sequencer.sv
// Directed bench for timer_config_sequencer: a cycle table for unsynced and
// round-robin updates, plus hand sequences for sync, timeout, run drop, reset.
module tb_timer_config_sequencer;

    localparam int N_REQ       = 2;
    localparam int LOAD_CYCLES = 2;
    localparam int TIMEOUT     = 15;

    logic       clk = 1'b0;
    logic       resetN;
    logic       runI;
    logic [1:0] reqVec;
    logic [1:0] syncVec;
    logic       periodComplete;
    logic [7:0] period0, presc0, period1, presc1;
    logic [1:0] ackO;
    logic       enO;
    logic [7:0] periodO, prescO;
    logic       busyO, timeoutO;

    int errorCount = 0;
    int checkCount = 0;

    timer_config_sequencer #(
        .N_REQ       (N_REQ),
        .LOAD_CYCLES (LOAD_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset_n           (resetN),
        .run_i             (runI),
        .req_i             (reqVec),
        .cfg_period_i      ({period1, period0}),
        .cfg_prescaler_i   ({presc1, presc0}),
        .cfg_sync_i        (syncVec),
        .period_complete_i (periodComplete),
        .ack_o             (ackO),
        .timer_enable_o    (enO),
        .period_o          (periodO),
        .prescaler_o       (prescO),
        .busy_o            (busyO),
        .sync_timeout_o    (timeoutO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic [1:0] req;
        logic       en;
        logic [7:0] per;
        logic [7:0] pre;
        logic [1:0] ack;
        logic       busy;
    } vec_t;

    vec_t vecs[23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic run, input logic [1:0] req, input logic pc);
        runI           = run;
        reqVec         = req;
        periodComplete = pc;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic en, input logic [7:0] per, input logic [7:0] pre,
                            input logic [1:0] ack, input logic busy, input logic to);
        checkOutput($sformatf("%s.en", tag), 32'(enO), 32'(en));
        checkOutput($sformatf("%s.period", tag), 32'(periodO), 32'(per));
        checkOutput($sformatf("%s.prescaler", tag), 32'(prescO), 32'(pre));
        checkOutput($sformatf("%s.ack", tag), 32'(ackO), 32'(ack));
        checkOutput($sformatf("%s.busy", tag), 32'(busyO), 32'(busy));
        checkOutput($sformatf("%s.timeout", tag), 32'(timeoutO), 32'(to));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // run, req, en, period, prescaler, ack, busy
        vecs[0]  = '{1'b1, 2'b00, 1'b1, 8'd255, 8'd0, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 8'd100, 8'd3, 2'b00, 1'b1};
        vecs[2]  = '{1'b1, 2'b01, 1'b0, 8'd100, 8'd3, 2'b00, 1'b1};
        vecs[3]  = '{1'b1, 2'b01, 1'b1, 8'd100, 8'd3, 2'b01, 1'b1};
        vecs[4]  = '{1'b1, 2'b01, 1'b1, 8'd100, 8'd3, 2'b01, 1'b1};
        vecs[5]  = '{1'b1, 2'b00, 1'b1, 8'd100, 8'd3, 2'b00, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 1'b1, 8'd100, 8'd3, 2'b00, 1'b0};
        vecs[7]  = '{1'b1, 2'b11, 1'b0, 8'd50,  8'd7, 2'b00, 1'b1};
        vecs[8]  = '{1'b1, 2'b11, 1'b0, 8'd50,  8'd7, 2'b00, 1'b1};
        vecs[9]  = '{1'b1, 2'b11, 1'b1, 8'd50,  8'd7, 2'b10, 1'b1};
        vecs[10] = '{1'b1, 2'b01, 1'b1, 8'd50,  8'd7, 2'b00, 1'b0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 8'd100, 8'd3, 2'b00, 1'b1};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 8'd100, 8'd3, 2'b00, 1'b1};
        vecs[13] = '{1'b1, 2'b11, 1'b1, 8'd100, 8'd3, 2'b01, 1'b1};
        vecs[14] = '{1'b1, 2'b10, 1'b1, 8'd100, 8'd3, 2'b00, 1'b0};
        vecs[15] = '{1'b1, 2'b10, 1'b0, 8'd50,  8'd7, 2'b00, 1'b1};
        vecs[16] = '{1'b1, 2'b11, 1'b0, 8'd50,  8'd7, 2'b00, 1'b1};
        vecs[17] = '{1'b1, 2'b11, 1'b1, 8'd50,  8'd7, 2'b10, 1'b1};
        vecs[18] = '{1'b1, 2'b01, 1'b1, 8'd50,  8'd7, 2'b00, 1'b0};
        vecs[19] = '{1'b1, 2'b01, 1'b0, 8'd100, 8'd3, 2'b00, 1'b1};
        vecs[20] = '{1'b1, 2'b01, 1'b0, 8'd100, 8'd3, 2'b00, 1'b1};
        vecs[21] = '{1'b1, 2'b01, 1'b1, 8'd100, 8'd3, 2'b01, 1'b1};
        vecs[22] = '{1'b1, 2'b00, 1'b1, 8'd100, 8'd3, 2'b00, 1'b0};

        resetN         = 1'b0;
        runI           = 1'b0;
        reqVec         = 2'b00;
        syncVec        = 2'b00;
        periodComplete = 1'b0;
        period0 = 8'd100; presc0 = 8'd3;
        period1 = 8'd50;  presc1 = 8'd7;

        #12;
        checkAll("reset", 1'b0, 8'd255, 8'd0, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Unsynced update followed by alternating round-robin grants.
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].run, vecs[i].req, 1'b0);
            checkAll($sformatf("vec%0d", i), vecs[i].en, vecs[i].per, vecs[i].pre,
                     vecs[i].ack, vecs[i].busy, 1'b0);
        end

        // Synced update: boundary pulse arrives after several wait cycles.
        period1 = 8'd60; presc1 = 8'd5; syncVec = 2'b10;
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkAll("sync_enter", 1'b1, 8'd100, 8'd3, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 2'b10, 1'b0);
            checkAll($sformatf("sync_wait%0d", k), 1'b1, 8'd100, 8'd3, 2'b00, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 2'b10, 1'b1);
        checkAll("sync_load0", 1'b0, 8'd60, 8'd5, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkAll("sync_load1", 1'b0, 8'd60, 8'd5, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkAll("sync_done", 1'b1, 8'd60, 8'd5, 2'b10, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkAll("sync_idle", 1'b1, 8'd60, 8'd5, 2'b00, 1'b0, 1'b0);

        // Sync timeout: no boundary ever arrives.
        period0 = 8'd120; presc0 = 8'd9; syncVec = 2'b01;
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkAll("to_enter", 1'b1, 8'd60, 8'd5, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < TIMEOUT; k++) begin
            applyStimulus(1'b1, 2'b01, 1'b0);
            checkAll($sformatf("to_wait%0d", k), 1'b1, 8'd60, 8'd5, 2'b00, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkAll("to_load0", 1'b0, 8'd120, 8'd9, 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkAll("to_load1", 1'b0, 8'd120, 8'd9, 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkAll("to_done", 1'b1, 8'd120, 8'd9, 2'b01, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkAll("to_idle", 1'b1, 8'd120, 8'd9, 2'b00, 1'b0, 1'b1);

        period1 = 8'd30; presc1 = 8'd2; syncVec = 2'b00;
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkAll("to_clear", 1'b0, 8'd30, 8'd2, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkAll("to_clear_load", 1'b0, 8'd30, 8'd2, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkAll("to_clear_done", 1'b1, 8'd30, 8'd2, 2'b10, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkAll("to_clear_idle", 1'b1, 8'd30, 8'd2, 2'b00, 1'b0, 1'b0);

        // run_i drops while waiting for a boundary.
        period0 = 8'd77; presc0 = 8'd4; syncVec = 2'b01;
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkAll("rd_enter", 1'b1, 8'd30, 8'd2, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 2'b01, 1'b0);
            checkAll($sformatf("rd_wait%0d", k), 1'b1, 8'd30, 8'd2, 2'b00, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 2'b01, 1'b0);
        checkAll("rd_load0", 1'b0, 8'd77, 8'd4, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0);
        checkAll("rd_load1", 1'b0, 8'd77, 8'd4, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0);
        checkAll("rd_done", 1'b0, 8'd77, 8'd4, 2'b01, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0);
        checkAll("rd_hold", 1'b0, 8'd77, 8'd4, 2'b01, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkAll("rd_idle", 1'b0, 8'd77, 8'd4, 2'b00, 1'b0, 1'b0);

        // Reset in the middle of a load; pointer must return to 0.
        period0 = 8'd200; presc0 = 8'd8; syncVec = 2'b00;
        applyStimulus(1'b1, 2'b01, 1'b0);
        checkAll("rst_pre", 1'b0, 8'd200, 8'd8, 2'b00, 1'b1, 1'b0);
        resetN = 1'b0;
        #1;
        checkAll("rst_async", 1'b0, 8'd255, 8'd0, 2'b00, 1'b0, 1'b0);
        tick();
        checkAll("rst_hold", 1'b0, 8'd255, 8'd0, 2'b00, 1'b0, 1'b0);
        reqVec = 2'b00;
        resetN = 1'b1;
        #1;
        checkAll("rst_release", 1'b0, 8'd255, 8'd0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkAll("rst_regrant", 1'b0, 8'd200, 8'd8, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkAll("rst_load1", 1'b0, 8'd200, 8'd8, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        checkAll("rst_done", 1'b1, 8'd200, 8'd8, 2'b01, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkAll("rst_idle", 1'b1, 8'd200, 8'd8, 2'b00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
